// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared op codes, exception bit indices and LSU state/size types
package mem_lsu_pkg;

  localparam logic [7:0] EXE_ADD_OP = 8'b00100000;
  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;

  localparam int LOAD_MISALIGN_BIT  = 4;
  localparam int STORE_MISALIGN_BIT = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  typedef struct packed {
    logic      is_mem;
    logic      is_store;
    logic      is_unsigned;
    lsu_size_e size;
  } lsu_op_t;

  // Classify an aluop into access kind, width and extension mode.
  function automatic lsu_op_t decode_op(input logic [7:0] op);
    lsu_op_t d;
    d.is_mem      = 1'b1;
    d.is_store    = 1'b0;
    d.is_unsigned = 1'b0;
    d.size        = SZ_WORD;
    case (op)
      EXE_LB_OP:  d.size = SZ_BYTE;
      EXE_LBU_OP: begin d.size = SZ_BYTE; d.is_unsigned = 1'b1; end
      EXE_LH_OP:  d.size = SZ_HALF;
      EXE_LHU_OP: begin d.size = SZ_HALF; d.is_unsigned = 1'b1; end
      EXE_LW_OP:  d.size = SZ_WORD;
      EXE_SB_OP:  begin d.size = SZ_BYTE; d.is_store = 1'b1; end
      EXE_SH_OP:  begin d.size = SZ_HALF; d.is_store = 1'b1; end
      EXE_SW_OP:  begin d.size = SZ_WORD; d.is_store = 1'b1; end
      default:    d.is_mem = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// rtl/mem_lsu_lane.sv - byte-lane select/store replication and load extraction/extension
module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  input  logic [1:0]  a,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = load_word[{a, 3'b000} +: 8];
  // Halfwords only look at a[1]; a[0] is either trapped upstream or ignored.
  assign lane_h = a[1] ? load_word[31:16] : load_word[15:0];

  // Per-width lane enables, store replication and load extension.
  always_comb begin
    sel       = 4'b1111;
    wdata     = store_data;
    load_data = load_word;
    case (size)
      SZ_BYTE: begin
        sel       = 4'b0001 << a;
        wdata     = {4{store_data[7:0]}};
        load_data = is_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        sel       = a[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = is_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      default: begin
        sel       = 4'b1111;
        wdata     = store_data;
        load_data = load_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit; MISALIGN_EXC_EN traps misaligned half/word accesses
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [4:0]        mem_wd,
  input  logic              mem_wreg,
  input  logic [31:0]       mem_wdata,
  input  logic [7:0]        mem_aluop,
  input  logic [ADDR_W-1:0] mem_mem_addr,
  input  logic [31:0]       mem_reg2,
  input  logic [31:0]       mem_excepttype,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_sel,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_ack,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [31:0]       wb_wdata,
  output logic [31:0]       wb_excepttype,
  output logic              stallreq
);

  lsu_state_e  state;
  lsu_op_t     dec;
  logic [31:0] rdata_q;
  logic        drop_q;
  logic        exc_pending;
  logic        misaligned;
  logic [31:0] misalign_exc;
  logic        start;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;

  assign dec         = decode_op(mem_aluop);
  assign exc_pending = |mem_excepttype;

`ifdef MISALIGN_EXC_EN
  assign misaligned = dec.is_mem &&
                      ((dec.size == SZ_HALF && mem_mem_addr[0]) ||
                       (dec.size == SZ_WORD && mem_mem_addr[1:0] != 2'b00));

  // Flag the misaligned access in the exception vector instead of touching the bus.
  always_comb begin
    misalign_exc = '0;
    if (misaligned) begin
      if (dec.is_store) misalign_exc[STORE_MISALIGN_BIT] = 1'b1;
      else              misalign_exc[LOAD_MISALIGN_BIT]  = 1'b1;
    end
  end
`else
  assign misaligned   = 1'b0;
  assign misalign_exc = '0;
`endif

  assign start = (state == ST_IDLE) && dec.is_mem && !exc_pending && !misaligned && !flush;

  mem_lsu_lane u_lane (
    .size        (dec.size),
    .is_unsigned (dec.is_unsigned),
    .a           (mem_mem_addr[1:0]),
    .store_data  (mem_reg2),
    .load_word   (rdata_q),
    .sel         (lane_sel),
    .wdata       (lane_wdata),
    .load_data   (lane_load)
  );

  // Bus handshake FSM: launch in IDLE, hold until ack in BUSY, one result cycle in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_sel   <= 4'b0000;
      dbus_wdata <= '0;
      rdata_q    <= '0;
      drop_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            dbus_req   <= 1'b1;
            dbus_we    <= dec.is_store;
            dbus_addr  <= {mem_mem_addr[ADDR_W-1:2], 2'b00};
            dbus_sel   <= lane_sel;
            dbus_wdata <= lane_wdata;
            drop_q     <= 1'b0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (flush) drop_q <= 1'b1;
          if (dbus_ack) begin
            rdata_q  <= dbus_rdata;
            dbus_req <= 1'b0;
            drop_q   <= 1'b0;
            // A flushed transaction still completes on the bus but never writes back.
            state    <= (drop_q || flush) ? ST_IDLE : ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Writeback path and stall request, combinational from state and the EX/MEM inputs.
  always_comb begin
    wb_wd         = mem_wd;
    wb_excepttype = mem_excepttype | misalign_exc;
    wb_wdata      = mem_wdata;
    wb_wreg       = 1'b0;
    stallreq      = start || (state == ST_BUSY);
    case (state)
      ST_IDLE: wb_wreg = mem_wreg && !dec.is_mem && !exc_pending;
      ST_DONE: begin
        if (dec.is_mem && !dec.is_store) begin
          wb_wdata = lane_load;
          wb_wreg  = mem_wreg && !flush && !drop_q;
        end
      end
      default: wb_wreg = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - self-checking bench for mem_lsu with a behavioural byte-lane model
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [31:0] mem_excepttype;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] wb_excepttype;
  logic        stallreq;

  int checks = 0;
  int errors = 0;

  mem_lsu dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .mem_wd         (mem_wd),
    .mem_wreg       (mem_wreg),
    .mem_wdata      (mem_wdata),
    .mem_aluop      (mem_aluop),
    .mem_mem_addr   (mem_mem_addr),
    .mem_reg2       (mem_reg2),
    .mem_excepttype (mem_excepttype),
    .dbus_req       (dbus_req),
    .dbus_we        (dbus_we),
    .dbus_addr      (dbus_addr),
    .dbus_sel       (dbus_sel),
    .dbus_wdata     (dbus_wdata),
    .dbus_ack       (dbus_ack),
    .dbus_rdata     (dbus_rdata),
    .wb_wd          (wb_wd),
    .wb_wreg        (wb_wreg),
    .wb_wdata       (wb_wdata),
    .wb_excepttype  (wb_excepttype),
    .stallreq       (stallreq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int op_bytes(input logic [7:0] op);
    if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    return 4;
  endfunction

  function automatic bit op_store(input logic [7:0] op);
    return (op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP);
  endfunction

  function automatic bit op_unsigned(input logic [7:0] op);
    return (op == EXE_LBU_OP || op == EXE_LHU_OP);
  endfunction

  function automatic int lane_off(input logic [7:0] op, input logic [31:0] addr);
    int n;
    n = op_bytes(op);
    return (int'(addr % 4) / n) * n;
  endfunction

  function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] addr);
    int n;
    n = op_bytes(op);
    return 4'(((1 << n) - 1) << lane_off(op, addr));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] reg2);
    int n;
    n = op_bytes(op);
    if (n == 1) return {24'b0, reg2[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'b0, reg2[15:0]} * 32'h0001_0001;
    return reg2;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int n;
    logic [31:0] v, mask;
    n = op_bytes(op);
    if (n == 4) return rdata;
    mask = (32'h1 << (8 * n)) - 32'h1;
    v = (rdata >> (8 * lane_off(op, addr))) & mask;
    if (!op_unsigned(op) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic wreg, input logic [31:0] wdata, input logic [4:0] wd);
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
    mem_wreg     = wreg;
    mem_wdata    = wdata;
    mem_wd       = wd;
  endtask

  task automatic bubble();
    drive(EXE_ADD_OP, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0);
    mem_excepttype = 32'h0;
    flush          = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic run_mem(input string nm, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] reg2, input logic [31:0] rdata, input int lat);
    int stall_cnt;
    bit st;
    st = op_store(op);
    stall_cnt = 0;
    drive(op, addr, reg2, 1'b1, 32'h1357_9BDF, 5'd11);
    #1;
    checks++;
    if (stallreq !== 1'b1 || wb_wreg !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_stall: stallreq=%b wb_wreg=%b want 1/0", nm, stallreq, wb_wreg);
    end
    if (stallreq === 1'b1) stall_cnt++;
    step();
    checks++;
    if (dbus_req !== 1'b1 || dbus_we !== st || dbus_addr !== {addr[31:2], 2'b00} ||
        dbus_sel !== m_sel(op, addr)) begin
      errors++;
      $display("FAIL %s bus_issue: req=%b we=%b addr=%h sel=%b want 1/%b/%h/%b", nm, dbus_req,
               dbus_we, dbus_addr, dbus_sel, st, {addr[31:2], 2'b00}, m_sel(op, addr));
    end
    if (st) begin
      checks++;
      if (dbus_wdata !== m_wdata(op, reg2)) begin
        errors++;
        $display("FAIL %s store_wdata: got %h want %h", nm, dbus_wdata, m_wdata(op, reg2));
      end
    end
    for (int i = 0; i < lat; i++) begin
      if (i == lat - 1) begin
        dbus_ack   = 1'b1;
        dbus_rdata = rdata;
      end
      checks++;
      if (dbus_req !== 1'b1 || stallreq !== 1'b1 || wb_wreg !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_hold: req=%b stall=%b wreg=%b want 1/1/0", nm, dbus_req,
                 stallreq, wb_wreg);
      end
      if (stallreq === 1'b1) stall_cnt++;
      step();
    end
    dbus_ack   = 1'b0;
    dbus_rdata = $urandom;
    #1;
    checks++;
    if (stallreq !== 1'b0 || dbus_req !== 1'b0 || wb_wreg !== !st) begin
      errors++;
      $display("FAIL %s done: stall=%b req=%b wreg=%b want 0/0/%b", nm, stallreq, dbus_req,
               wb_wreg, !st);
    end
    checks++;
    if (stall_cnt != lat + 1) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d want %0d", nm, stall_cnt, lat + 1);
    end
    if (!st) begin
      checks++;
      if (wb_wdata !== m_load(op, addr, rdata)) begin
        errors++;
        $display("FAIL %s load_data: got %h want %h", nm, wb_wdata, m_load(op, addr, rdata));
      end
    end
    step();
    bubble();
    #1;
    checks++;
    if (stallreq !== 1'b0 || dbus_req !== 1'b0) begin
      errors++;
      $display("FAIL %s no_reissue: stall=%b req=%b want 0/0", nm, stallreq, dbus_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bubble();
    dbus_ack   = 1'b0;
    dbus_rdata = 32'h0;
    drive(EXE_ADD_OP, 32'h0, 32'h0, 1'b1, 32'h55, 5'd3);
    step();
    step();
    checks++;
    if (dbus_req !== 1'b0 || dbus_we !== 1'b0 || dbus_addr !== 32'h0 || dbus_sel !== 4'h0 ||
        dbus_wdata !== 32'h0 || stallreq !== 1'b0 || wb_wdata !== 32'h55 || wb_wreg !== 1'b1) begin
      errors++;
      $display("FAIL reset: req=%b we=%b addr=%h sel=%b wdata=%h stall=%b wbd=%h wreg=%b",
               dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata, stallreq, wb_wdata, wb_wreg);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_passthrough();
    drive(EXE_ADD_OP, 32'h40, 32'h0, 1'b1, 32'h5, 5'd7);
    #1;
    checks++;
    if (wb_wd !== 5'd7 || wb_wreg !== 1'b1 || wb_wdata !== 32'h5 || stallreq !== 1'b0 ||
        wb_excepttype !== 32'h0) begin
      errors++;
      $display("FAIL passthrough: wd=%0d wreg=%b wdata=%h stall=%b want 7/1/5/0", wb_wd,
               wb_wreg, wb_wdata, stallreq);
    end
    step();
    checks++;
    if (dbus_req !== 1'b0) begin
      errors++;
      $display("FAIL passthrough_noreq: req=%b want 0", dbus_req);
    end
    bubble();
  endtask

  task automatic test_flush_busy();
    drive(EXE_LW_OP, 32'h300, 32'h0, 1'b1, 32'h0, 5'd4);
    step();
    flush = 1'b1;
    drive(EXE_ADD_OP, 32'h0, 32'h0, 1'b1, 32'h77, 5'd9);
    step();
    flush = 1'b0;
    checks++;
    if (dbus_req !== 1'b1 || stallreq !== 1'b1 || wb_wreg !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy_hold: req=%b stall=%b wreg=%b want 1/1/0", dbus_req, stallreq,
               wb_wreg);
    end
    dbus_ack   = 1'b1;
    dbus_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (dbus_req !== 1'b1 || stallreq !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy_ack: req=%b stall=%b want 1/1", dbus_req, stallreq);
    end
    step();
    dbus_ack = 1'b0;
    #1;
    checks++;
    if (dbus_req !== 1'b0 || stallreq !== 1'b0 || wb_wreg !== 1'b1 || wb_wdata !== 32'h77) begin
      errors++;
      $display("FAIL flush_busy_idle: req=%b stall=%b wreg=%b wdata=%h want 0/0/1/77", dbus_req,
               stallreq, wb_wreg, wb_wdata);
    end
    bubble();
    step();
  endtask

  task automatic test_ack_flush();
    drive(EXE_LW_OP, 32'h310, 32'h0, 1'b1, 32'h0, 5'd4);
    step();
    flush      = 1'b1;
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h1111_2222;
    drive(EXE_ADD_OP, 32'h0, 32'h0, 1'b1, 32'h99, 5'd2);
    step();
    flush    = 1'b0;
    dbus_ack = 1'b0;
    #1;
    checks++;
    if (dbus_req !== 1'b0 || stallreq !== 1'b0 || wb_wreg !== 1'b1 || wb_wdata !== 32'h99) begin
      errors++;
      $display("FAIL ack_flush: req=%b stall=%b wreg=%b wdata=%h want 0/0/1/99", dbus_req,
               stallreq, wb_wreg, wb_wdata);
    end
    bubble();
    step();
  endtask

  task automatic test_flush_idle();
    flush = 1'b1;
    drive(EXE_SW_OP, 32'h400, 32'h1234, 1'b0, 32'h0, 5'd0);
    #1;
    checks++;
    if (stallreq !== 1'b0 || wb_wreg !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: stall=%b wreg=%b want 0/0", stallreq, wb_wreg);
    end
    step();
    bubble();
    checks++;
    if (dbus_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_noreq: req=%b want 0", dbus_req);
    end
    step();
  endtask

  task automatic test_exception();
    drive(EXE_LW_OP, 32'h500, 32'h0, 1'b1, 32'hAA, 5'd6);
    mem_excepttype = 32'h0000_0008;
    #1;
    checks++;
    if (stallreq !== 1'b0 || wb_wreg !== 1'b0 || wb_excepttype !== 32'h8 || wb_wdata !== 32'hAA) begin
      errors++;
      $display("FAIL exception: stall=%b wreg=%b exc=%h wdata=%h want 0/0/8/aa", stallreq,
               wb_wreg, wb_excepttype, wb_wdata);
    end
    step();
    checks++;
    if (dbus_req !== 1'b0) begin
      errors++;
      $display("FAIL exception_noreq: req=%b want 0", dbus_req);
    end
    bubble();
    step();
  endtask

`ifdef MISALIGN_EXC_EN
  task automatic test_misalign();
    drive(EXE_LW_OP, 32'h101, 32'h0, 1'b1, 32'h0, 5'd5);
    #1;
    checks++;
    if (stallreq !== 1'b0 || wb_wreg !== 1'b0 || wb_excepttype !== 32'h10) begin
      errors++;
      $display("FAIL misalign_load: stall=%b wreg=%b exc=%h want 0/0/10", stallreq, wb_wreg,
               wb_excepttype);
    end
    step();
    checks++;
    if (dbus_req !== 1'b0) begin
      errors++;
      $display("FAIL misalign_load_noreq: req=%b want 0", dbus_req);
    end
    drive(EXE_SH_OP, 32'h103, 32'hBEEF, 1'b0, 32'h0, 5'd0);
    #1;
    checks++;
    if (stallreq !== 1'b0 || wb_excepttype !== 32'h40) begin
      errors++;
      $display("FAIL misalign_store: stall=%b exc=%h want 0/40", stallreq, wb_excepttype);
    end
    step();
    bubble();
    step();
  endtask
`else
  task automatic test_misalign();
    run_mem("lw_forced_align", EXE_LW_OP, 32'h101, 32'h0, 32'hA5A5_0F0F, 1);
    run_mem("sh_forced_align", EXE_SH_OP, 32'h103, 32'h0000_BEEF, 32'h0, 2);
  endtask
`endif

  task automatic test_random();
    logic [7:0] ops [8];
    logic [7:0] op;
    logic [31:0] addr;
    ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    for (int k = 0; k < 40; k++) begin
      op   = ops[$urandom_range(0, 7)];
      addr = $urandom;
`ifdef MISALIGN_EXC_EN
      addr = addr & ~(32'(op_bytes(op)) - 32'h1);
`endif
      run_mem("random", op, addr, $urandom, $urandom, int'($urandom_range(1, 4)));
    end
  endtask

  task automatic test_directed();
    run_mem("sw_0x100", EXE_SW_OP, 32'h100, 32'hDEAD_BEEF, 32'h0, 3);
    run_mem("lb_0x203", EXE_LB_OP, 32'h203, 32'h0, 32'h80FF_FFFF, 1);
    run_mem("lbu_0x203", EXE_LBU_OP, 32'h203, 32'h0, 32'h80FF_FFFF, 2);
    run_mem("lh_0x202", EXE_LH_OP, 32'h202, 32'h0, 32'h1234_ABCD, 1);
    run_mem("lhu_0x200", EXE_LHU_OP, 32'h200, 32'h0, 32'h1234_ABCD, 1);
    run_mem("sb_0x201", EXE_SB_OP, 32'h201, 32'h0000_00A7, 32'h0, 1);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_directed();
    test_flush_busy();
    test_ack_flush();
    test_flush_idle();
    test_exception();
    test_misalign();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
MEM-stage load/store unit, directly downstream of the EX/MEM pipeline register.
- Non-memory instructions pass to MEM/WB unchanged in the same cycle.
- LB/LH/LW/LBU/LHU/SB/SH/SW run a req/ack transaction on the data bus.
- Asserts stallreq to the pipeline controller until the transaction finishes.
- Byte-lane steers store data and sign/zero-extends load data.

Parameters:
- ADDR_W, 32, data bus address width.
- DATA_W, 32, data bus width; fixed at 32 for RV32I (byte-lane logic assumes 4 lanes).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush from controller
- mem_wd  in  5  destination register
- mem_wreg  in  1  register write enable
- mem_wdata  in  32  ALU result
- mem_aluop  in  8  operation code (load/store codes from shared package)
- mem_mem_addr  in  32  effective address
- mem_reg2  in  32  store data
- mem_excepttype  in  32  exception vector from EX
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = store
- dbus_addr  out  32  word-aligned address, bits[1:0] = 0
- dbus_sel  out  4  byte-lane enables
- dbus_wdata  out  32  lane-replicated store data
- dbus_ack  in  1  one-cycle completion pulse
- dbus_rdata  in  32  read data, valid when ack = 1
- wb_wd  out  5  destination register to MEM/WB
- wb_wreg  out  1  write enable to MEM/WB
- wb_wdata  out  32  writeback data to MEM/WB
- wb_excepttype  out  32  exception vector to MEM/WB
- stallreq  out  1  stall request to controller

Behaviour:
- FSM states: IDLE, BUSY, DONE. Bus outputs and rdata_q are registered; wb_* and stallreq are combinational from state and inputs.
- Reset: state = IDLE, dbus_req = 0, dbus_we = 0, dbus_addr = 0, dbus_sel = 0, dbus_wdata = 0, rdata_q = 0, drop_q = 0. wb_* are then 0 / pass-through and stallreq = 0. Reset mid-transaction drops req immediately; the bus slave is reset by the same rst.
- IDLE, non-memory op:
  - wb_wd, wb_wreg, wb_wdata and wb_excepttype mirror the inputs combinationally; stallreq = 0.
- IDLE, memory op (no exception pending, flush = 0):
  - stallreq = 1 combinationally.
  - Next edge: registers req/we/addr/sel/wdata, then goes to BUSY.
  - wb_wreg = 0 while stalled.
- BUSY:
  - stallreq = 1. Bus outputs are held stable; req is never withdrawn before ack.
  - On ack: rdata_q <= dbus_rdata; req <= 0; go to DONE.
- DONE (one cycle):
  - stallreq = 0.
  - Loads: wb_wdata = extracted rdata_q, wb_wreg = mem_wreg.
  - Stores: wb_wreg = 0.
  - Next edge: IDLE. EX/MEM advances on that same edge, so the op is not reissued.
- Lane rules (a = addr[1:0]):
  - Byte: sel = 1 << a; wdata = {4{reg2[7:0]}}.
  - Half: sel = 0011 when a[1] = 0, 1100 when a[1] = 1; wdata = {2{reg2[15:0]}}.
  - Word: sel = 1111.
  - LB/LH sign-extend the selected lane; LBU/LHU zero-extend it.
- Exception pending (mem_excepttype != 0): no bus access; outputs pass through with wb_wreg = 0.
- Flush:
  - In IDLE: no request is issued.
  - In BUSY: the transaction completes. drop_q is set, stallreq stays 1 until ack, then the FSM returns directly to IDLE with wb_wreg = 0.
  - In DONE: wb_wreg = 0.
- Simultaneous ack and flush in BUSY: the result is dropped and the FSM goes to IDLE.

Optional Feature:
MISALIGN_EXC_EN
- Defined: halfword at a[0] = 1 or word at a != 0 issues no bus request and raises no stall. wb_excepttype = mem_excepttype with bit 4 (load misaligned) or bit 6 (store misaligned) set, and wb_wreg = 0.
- Undefined: the address is forced aligned (half: a[0] ignored; word: a ignored) and the access proceeds.

Decomposition:
- Shared define file: EXE_LB_OP … EXE_SW_OP codes, misaligned excepttype bit indices, state encodings.
- One sub-module, lsu_lane: combinational sel/wdata generation and load extraction/extension.

Test Plan:
- SW addr 0x100, reg2 0xDEADBEEF, ack after 3 cycles -> req/we = 1, sel = 1111, stallreq high 4 cycles, wb_wreg = 0.
- LB addr 0x203, rdata 0x80FFFFFF -> sel = 1000, wb_wdata = 0xFFFFFF80. LBU on the same data -> 0x00000080.
- LH addr 0x202, rdata 0x1234ABCD -> sel = 1100, wb_wdata = 0x00001234.
- ADD with wdata 0x5 -> same-cycle pass-through, wb_wreg = 1, stallreq = 0, no req.
- LW with flush asserted in BUSY, ack 2 cycles later -> req held until ack, wb_wreg stays 0, returns to IDLE.
- LW addr 0x101 with MISALIGN_EXC_EN defined -> no req, wb_excepttype bit 4 = 1.
